// File: rtl/mole_scheduler.sv
// Whack-a-mole game controller: picks holes from the LFSR, times mole visibility
// and feedback flashes, scores hits, counts misses and declares game over.
module mole_scheduler #(
   parameter int TICKS_SHOW  = 800,
   parameter int GAP_BASE    = 200,
   parameter int FLASH_TICKS = 100,
   parameter int MAX_MISS    = 5,
   parameter int SCORE_W     = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick,
   input  logic               start,
   input  logic [7:0]         key_hit,
   input  logic [2:0]         rand3,
   input  logic [7:0]         rand8,
   output logic [7:0]         mole,
   output logic [2:0]         hole_idx,
   output logic               hit_pulse,
   output logic               miss_pulse,
   output logic [SCORE_W-1:0] score,
   output logic [3:0]         misses,
   output logic               game_over,
   output logic               busy
);

   // Counter must hold the largest of the gap, show and flash loads.
   localparam int GAP_MAX = GAP_BASE + 255;
   localparam int MAX_A   = (GAP_MAX > TICKS_SHOW) ? GAP_MAX : TICKS_SHOW;
   localparam int CNT_MAX = (MAX_A > FLASH_TICKS) ? MAX_A : FLASH_TICKS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(TICKS_SHOW);
   localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_TICKS);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_BASE);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [3:0]       MISS_LIMIT = 4'(MAX_MISS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GAP,
      S_SHOW,
      S_HIT,
      S_MISS,
      S_OVER
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         mole_q, mole_d;
   logic [2:0]         hole_idx_q, hole_idx_d;
   logic               hit_pulse_q, hit_pulse_d;
   logic               miss_pulse_q, miss_pulse_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [3:0]         misses_q, misses_d;
   logic [2:0]         last_hole_q, last_hole_d;
   logic               last_valid_q, last_valid_d;
   logic               game_over_q, game_over_d;
   logic               busy_q, busy_d;

   logic [2:0]         pick_idx;
   logic [CNT_W-1:0]   gap_load;
   logic [CNT_W-1:0]   cnt_dec;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      mole_d       = mole_q;
      hole_idx_d   = hole_idx_q;
      hit_pulse_d  = 1'b0;
      miss_pulse_d = 1'b0;
      score_d      = score_q;
      misses_d     = misses_q;
      last_hole_d  = last_hole_q;
      last_valid_d = last_valid_q;
      game_over_d  = game_over_q;
      busy_d       = busy_q;

      // Never show the same hole twice in a row: bump a repeat to the next hole.
      pick_idx = (last_valid_q && (rand3 == last_hole_q)) ? rand3 + 3'd1 : rand3;
      gap_load = GAP_LOAD + CNT_W'(rand8);
      cnt_dec  = cnt_q - CNT_ONE;

      case (state_q)
         S_IDLE, S_OVER: begin
            if (start) begin
               score_d      = '0;
               misses_d     = '0;
               last_valid_d = 1'b0;
               mole_d       = '0;
               cnt_d        = gap_load;
               game_over_d  = 1'b0;
               busy_d       = 1'b1;
               state_d      = S_GAP;
            end
         end
         S_GAP: begin
            if (tick) begin
               if (cnt_q == CNT_ONE) begin
                  hole_idx_d   = pick_idx;
                  mole_d       = 8'd1 << pick_idx;
                  last_hole_d  = pick_idx;
                  last_valid_d = 1'b1;
                  cnt_d        = SHOW_LOAD;
                  state_d      = S_SHOW;
               end else begin
                  cnt_d = cnt_dec;
               end
            end
         end
         S_SHOW: begin
            // A hit on the same cycle as the final tick still counts as a hit.
            if (key_hit[hole_idx_q]) begin
               mole_d      = '0;
               hit_pulse_d = 1'b1;
               score_d     = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
               cnt_d       = FLASH_LOAD;
               state_d     = S_HIT;
            end else if (tick) begin
               if (cnt_q == CNT_ONE) begin
                  mole_d       = '0;
                  miss_pulse_d = 1'b1;
                  misses_d     = misses_q + 4'd1;
                  cnt_d        = FLASH_LOAD;
                  state_d      = S_MISS;
               end else begin
                  cnt_d = cnt_dec;
               end
            end
         end
         S_HIT, S_MISS: begin
            if (tick) begin
               if (cnt_q == CNT_ONE) begin
                  if (misses_q == MISS_LIMIT) begin
                     game_over_d = 1'b1;
                     busy_d      = 1'b0;
                     state_d     = S_OVER;
                  end else begin
                     cnt_d   = gap_load;
                     state_d = S_GAP;
                  end
               end else begin
                  cnt_d = cnt_dec;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         mole_q       <= '0;
         hole_idx_q   <= '0;
         hit_pulse_q  <= 1'b0;
         miss_pulse_q <= 1'b0;
         score_q      <= '0;
         misses_q     <= '0;
         last_hole_q  <= '0;
         last_valid_q <= 1'b0;
         game_over_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mole_q       <= mole_d;
         hole_idx_q   <= hole_idx_d;
         hit_pulse_q  <= hit_pulse_d;
         miss_pulse_q <= miss_pulse_d;
         score_q      <= score_d;
         misses_q     <= misses_d;
         last_hole_q  <= last_hole_d;
         last_valid_q <= last_valid_d;
         game_over_q  <= game_over_d;
         busy_q       <= busy_d;
      end
   end

   assign mole       = mole_q;
   assign hole_idx   = hole_idx_q;
   assign hit_pulse  = hit_pulse_q;
   assign miss_pulse = miss_pulse_q;
   assign score      = score_q;
   assign misses     = misses_q;
   assign game_over  = game_over_q;
   assign busy       = busy_q;

endmodule
